// File: rtl/plic_pkg.sv
// plic_pkg: register map offsets, parameter limits and decode kinds
// shared by the APB4 PLIC blocks.
package plic_pkg;

  localparam int MAX_IRQ    = 32;
  localparam int MAX_CTX    = 4;
  localparam int MAX_PRIO_W = 7;

  localparam logic [11:0] PRIO_OFF = 12'h000;
  localparam logic [11:0] PEND_OFF = 12'h080;
  localparam logic [11:0] TRIG_OFF = 12'h084;
  localparam logic [11:0] EN_OFF   = 12'h100;
  localparam logic [11:0] THR_OFF  = 12'h200;
  localparam logic [11:0] CLM_OFF  = 12'h204;

  typedef enum logic [2:0] {
    R_NONE,
    R_PRIO,
    R_PEND,
    R_TRIG,
    R_EN,
    R_THR,
    R_CLM
  } reg_e;

endpackage

// File: rtl/plic_gateway.sv
// plic_gateway: per-source gate; forwards one request, then masks the
// source until the handler completes it (level or rising-edge input).
module plic_gateway (
  input  logic clk_i,
  input  logic rst_i,
  input  logic irq,
  input  logic edge_sel,
  input  logic claim,
  input  logic comp,
  output logic valid
);

  logic mask;
  logic irq_q;

  // completion reopens the gate in the same cycle so a held level re-pends
  always_comb begin
    valid = (edge_sel ? (irq & ~irq_q) : irq) & (~mask | comp);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      mask  <= 1'b0;
      irq_q <= 1'b0;
    end else begin
      irq_q <= irq;
      if (valid | claim) mask <= 1'b1;
      else if (comp)     mask <= 1'b0;
    end
  end

endmodule

// File: rtl/apb4_plic_ctx.sv
// apb4_plic_ctx: APB4 PLIC with per-context claim/complete.
// Define PLIC_EDGE_TRIG_EN for per-source rising-edge triggers at 0x084.
module apb4_plic_ctx
  import plic_pkg::*;
#(
  parameter int IRQ_NUM    = 32,
  parameter int CTX_NUM    = 2,
  parameter int PRIO_WIDTH = 3
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [11:0]        paddr_i,
  input  logic               psel_i,
  input  logic               penable_i,
  input  logic               pwrite_i,
  input  logic [31:0]        pwdata_i,
  output logic [31:0]        prdata_o,
  output logic               pready_o,
  output logic               pslverr_o,
  input  logic [IRQ_NUM-1:0] irq_i,
  output logic [CTX_NUM-1:0] eip_o
);

  localparam int IDW = $clog2(IRQ_NUM);

  if (IRQ_NUM < 2 || IRQ_NUM > MAX_IRQ ||
      CTX_NUM < 1 || CTX_NUM > MAX_CTX ||
      PRIO_WIDTH < 1 || PRIO_WIDTH > MAX_PRIO_W) begin : g_bad
    $error("apb4_plic_ctx: parameter out of range");
  end

  logic [PRIO_WIDTH-1:0] prio [IRQ_NUM];
  logic [IRQ_NUM-1:0]    en   [CTX_NUM];
  logic [PRIO_WIDTH-1:0] thr  [CTX_NUM];
  logic [IDW-1:0]        max_id [CTX_NUM];
  logic [PRIO_WIDTH-1:0] max_p  [CTX_NUM];
  logic [IRQ_NUM-1:0]    ip, trig, gw_valid, clm, comp;
  reg_e                  sel;
  logic [4:0]            src;
  logic [1:0]            ectx, tctx;
  logic                  acc, err, wr, rd;
  logic [31:0]           rdata;
  logic                  unused;

  assign src  = paddr_i[6:2];
  assign ectx = paddr_i[3:2];
  assign tctx = paddr_i[4:3];

  always_comb begin
    sel = R_NONE;
    if (paddr_i[1:0] == 2'b00) begin
      if (paddr_i[11:7] == PRIO_OFF[11:7] && {27'd0, src} < 32'(IRQ_NUM))
        sel = R_PRIO;
      else if (paddr_i == PEND_OFF)
        sel = R_PEND;
`ifdef PLIC_EDGE_TRIG_EN
      else if (paddr_i == TRIG_OFF)
        sel = R_TRIG;
`endif
      else if (paddr_i[11:4] == EN_OFF[11:4] && {30'd0, ectx} < 32'(CTX_NUM))
        sel = R_EN;
      else if (paddr_i[11:5] == THR_OFF[11:5] && {30'd0, tctx} < 32'(CTX_NUM))
        sel = (paddr_i[2] == CLM_OFF[2]) ? R_CLM : R_THR;
    end
  end

  assign acc       = psel_i & penable_i;
  assign err       = (sel == R_NONE) | (pwrite_i & (sel == R_PEND));
  assign wr        = acc & pwrite_i & ~err;
  assign rd        = acc & ~pwrite_i & ~err;
  assign pready_o  = 1'b1;
  assign pslverr_o = acc & err;
  assign prdata_o  = rd ? rdata : 32'd0;

  // ascending scan with strict '>' keeps the lowest ID on priority ties
  always_comb begin
    for (int c = 0; c < CTX_NUM; c++) begin
      max_id[c] = '0;
      max_p[c]  = thr[c];
      for (int i = 1; i < IRQ_NUM; i++) begin
        if (ip[i] && en[c][i] && prio[i] > max_p[c]) begin
          max_p[c]  = prio[i];
          max_id[c] = IDW'(i);
        end
      end
    end
  end

  always_comb begin
    clm  = '0;
    comp = '0;
    for (int c = 0; c < CTX_NUM; c++) begin
      if (acc && !err && sel == R_CLM && tctx == 2'(c)) begin
        for (int i = 1; i < IRQ_NUM; i++) begin
          if (!pwrite_i && max_id[c] == IDW'(i)) clm[i] = 1'b1;
          if (pwrite_i && pwdata_i == 32'(i) && en[c][i]) comp[i] = 1'b1;
        end
      end
    end
  end

  always_comb begin
    rdata = '0;
    unique case (sel)
      R_PRIO:
        for (int i = 0; i < IRQ_NUM; i++)
          if (src == 5'(i)) rdata = 32'(prio[i]);
      R_PEND: rdata = 32'(ip);
      R_TRIG: rdata = 32'(trig);
      R_EN:
        for (int c = 0; c < CTX_NUM; c++)
          if (ectx == 2'(c)) rdata = 32'(en[c]);
      R_THR:
        for (int c = 0; c < CTX_NUM; c++)
          if (tctx == 2'(c)) rdata = 32'(thr[c]);
      R_CLM:
        for (int c = 0; c < CTX_NUM; c++)
          if (tctx == 2'(c)) rdata = 32'(max_id[c]);
      default: rdata = '0;
    endcase
  end

  assign gw_valid[0] = 1'b0;
  for (genvar i = 1; i < IRQ_NUM; i++) begin : g_gw
    plic_gateway u_gw (
      .clk_i    (clk_i),
      .rst_i    (rst_i),
      .irq      (irq_i[i]),
      .edge_sel (trig[i]),
      .claim    (clm[i]),
      .comp     (comp[i]),
      .valid    (gw_valid[i])
    );
  end

`ifndef PLIC_EDGE_TRIG_EN
  assign trig = '0;
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ip    <= '0;
      eip_o <= '0;
      for (int i = 0; i < IRQ_NUM; i++) prio[i] <= '0;
      for (int c = 0; c < CTX_NUM; c++) begin
        en[c]  <= '0;
        thr[c] <= '0;
      end
`ifdef PLIC_EDGE_TRIG_EN
      trig <= '0;
`endif
    end else begin
      for (int i = 1; i < IRQ_NUM; i++) begin
        if (clm[i])           ip[i] <= 1'b0;
        else if (gw_valid[i]) ip[i] <= 1'b1;
        if (wr && sel == R_PRIO && src == 5'(i))
          prio[i] <= pwdata_i[PRIO_WIDTH-1:0];
      end
      for (int c = 0; c < CTX_NUM; c++) begin
        if (wr && sel == R_EN && ectx == 2'(c))
          en[c] <= {pwdata_i[IRQ_NUM-1:1], 1'b0};
        if (wr && sel == R_THR && tctx == 2'(c))
          thr[c] <= pwdata_i[PRIO_WIDTH-1:0];
        eip_o[c] <= (max_id[c] != '0);
      end
`ifdef PLIC_EDGE_TRIG_EN
      if (wr && sel == R_TRIG)
        trig <= {pwdata_i[IRQ_NUM-1:1], 1'b0};
`endif
    end
  end

  assign unused = ^{irq_i[0], trig[0], clm[0], comp[0], gw_valid[0]};

endmodule

// File: tb/tb_apb4_plic_ctx.sv
// tb_apb4_plic_ctx: directed register-map scenarios plus random traffic
// scored against a priority-walk reference model of the PLIC.
module tb_apb4_plic_ctx;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [11:0] paddr = '0;
  logic        psel = 1'b0;
  logic        penable = 1'b0;
  logic        pwrite = 1'b0;
  logic [31:0] pwdata = '0;
  logic [31:0] prdata;
  logic        pready;
  logic        pslverr;
  logic [31:0] irq = '0;
  logic [1:0]  eip;

  int n_cmp = 0;
  int n_err = 0;

  int          m_prio [32];
  logic [31:0] m_en   [2];
  int          m_thr  [2];
  logic [31:0] m_ip;
  logic [31:0] m_mask;
  int          last   [2];

  always #5 clk = ~clk;

  apb4_plic_ctx dut (
    .clk_i     (clk),
    .rst_i     (rst),
    .paddr_i   (paddr),
    .psel_i    (psel),
    .penable_i (penable),
    .pwrite_i  (pwrite),
    .pwdata_i  (pwdata),
    .prdata_o  (prdata),
    .pready_o  (pready),
    .pslverr_o (pslverr),
    .irq_i     (irq),
    .eip_o     (eip)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic apb(input logic w, input logic [11:0] a,
                     input logic [31:0] d, output logic [31:0] r,
                     output logic e);
    @(negedge clk);
    psel = 1'b1; penable = 1'b0; pwrite = w; paddr = a; pwdata = d;
    @(negedge clk);
    penable = 1'b1;
    #1;
    r = prdata;
    e = pslverr;
    @(posedge clk);
    #1;
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
  endtask

  task automatic wr(input logic [11:0] a, input logic [31:0] d);
    logic [31:0] r;
    logic e;
    apb(1'b1, a, d, r, e);
  endtask

  task automatic rd_chk(input string tag, input logic [11:0] a,
                        input logic [31:0] exp);
    logic [31:0] r;
    logic e;
    apb(1'b0, a, 32'd0, r, e);
    chk(tag, r, exp);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    irq = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic pulse(input int b);
    @(negedge clk);
    irq[b] = 1'b1;
    @(negedge clk);
    irq[b] = 1'b0;
  endtask

  // highest priority level first, lowest ID within a level
  function automatic int m_maxid(input int c);
    for (int p = 7; p > m_thr[c]; p--)
      for (int i = 1; i < 32; i++)
        if (m_ip[i] && m_en[c][i] && m_prio[i] == p) return i;
    return 0;
  endfunction

  function automatic void m_settle();
    logic [31:0] nw;
    nw = irq & ~m_mask & 32'hFFFF_FFFE;
    m_ip   = m_ip | nw;
    m_mask = m_mask | nw;
  endfunction

  task automatic setup_a();
    wr(12'h00C, 32'd2);
    wr(12'h014, 32'd2);
    wr(12'h100, 32'h28);
    wr(12'h200, 32'd1);
  endtask

  initial begin : watchdog
    #2ms;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1);
  end

  initial begin : main
    logic [31:0] r;
    logic e;
    int c;
    int id;
    int op;
    logic [31:0] d;

    // reset state
    do_reset();
    chk("rst_eip", 32'(eip), 32'd0);
    chk("pready", 32'(pready), 32'd1);
    rd_chk("rst_pend", 12'h080, 32'd0);
    rd_chk("rst_prio1", 12'h004, 32'd0);
    rd_chk("rst_en0", 12'h100, 32'd0);
    rd_chk("rst_thr1", 12'h208, 32'd0);
    rd_chk("rst_clm0", 12'h204, 32'd0);

    // two equal-priority sources on context 0
    setup_a();
    irq[3] = 1'b1;
    irq[5] = 1'b1;
    idle(3);
    chk("a_eip0", 32'(eip[0]), 32'd1);
    rd_chk("a_pend", 12'h080, 32'h28);
    rd_chk("a_clm3", 12'h204, 32'd3);
    rd_chk("a_pend_c", 12'h080, 32'h20);
    irq[3] = 1'b0;
    wr(12'h204, 32'd3);
    idle(2);
    rd_chk("a_clm5", 12'h204, 32'd5);
    rd_chk("a_pend0", 12'h080, 32'h0);
    wr(12'h204, 32'd5);
    idle(2);
    rd_chk("a_repend", 12'h080, 32'h20);

    // threshold gating on context 1
    wr(12'h208, 32'd2);
    wr(12'h01C, 32'd2);
    wr(12'h104, 32'h80);
    irq[7] = 1'b1;
    idle(3);
    chk("b_eip1_off", 32'(eip[1]), 32'd0);
    wr(12'h208, 32'd1);
    chk("b_eip1_lat", 32'(eip[1]), 32'd0);
    idle(1);
    chk("b_eip1_on", 32'(eip[1]), 32'd1);

    // empty claim, priority-0 pending, foreign complete
    rd_chk("c_clm7", 12'h20C, 32'd7);
    rd_chk("c_pend", 12'h080, 32'h20);
    rd_chk("c_clm_none", 12'h20C, 32'd0);
    rd_chk("c_pend_same", 12'h080, 32'h20);
    irq[9] = 1'b1;
    idle(3);
    rd_chk("c_pend9", 12'h080, 32'h220);
    rd_chk("c_prio0", 12'h20C, 32'd0);
    wr(12'h024, 32'd1);
    wr(12'h104, 32'h281);
    rd_chk("c_en1", 12'h104, 32'h280);
    wr(12'h208, 32'd0);
    rd_chk("c_clm9", 12'h20C, 32'd9);
    wr(12'h204, 32'd9);
    idle(3);
    rd_chk("c_masked9", 12'h080, 32'h20);
    wr(12'h20C, 32'd9);
    idle(2);
    rd_chk("c_repend9", 12'h080, 32'h220);

    // error responses
    apb(1'b1, 12'h080, 32'hFFFF_FFFF, r, e);
    chk("d_wpend_err", 32'(e), 32'd1);
    rd_chk("d_pend_keep", 12'h080, 32'h220);
    apb(1'b0, 12'h300, 32'd0, r, e);
    chk("d_rd300_err", 32'(e), 32'd1);
    chk("d_rd300_dat", r, 32'd0);
    apb(1'b0, 12'h210, 32'd0, r, e);
    chk("d_thr2_err", 32'(e), 32'd1);
    apb(1'b0, 12'h080, 32'd0, r, e);
    chk("d_pend_ok", 32'(e), 32'd0);
    apb(1'b0, 12'h084, 32'd0, r, e);
`ifdef PLIC_EDGE_TRIG_EN
    chk("d_trig_ok", 32'(e), 32'd0);
`else
    chk("d_trig_err", 32'(e), 32'd1);
`endif

`ifdef PLIC_EDGE_TRIG_EN
    // rising-edge source 4
    do_reset();
    wr(12'h084, 32'h11);
    rd_chk("e_trig", 12'h084, 32'h10);
    wr(12'h010, 32'd1);
    wr(12'h100, 32'h10);
    pulse(4);
    idle(3);
    rd_chk("e_pend1", 12'h080, 32'h10);
    rd_chk("e_clm4", 12'h204, 32'd4);
    pulse(4);
    idle(3);
    rd_chk("e_dropped", 12'h080, 32'h0);
    wr(12'h204, 32'd4);
    idle(3);
    rd_chk("e_nolevel", 12'h080, 32'h0);
    pulse(4);
    idle(3);
    rd_chk("e_repend", 12'h080, 32'h10);
`endif

    // reset in the middle of activity
    do_reset();
    setup_a();
    irq[3] = 1'b1;
    irq[5] = 1'b1;
    idle(3);
    rd_chk("f_pend", 12'h080, 32'h28);
    chk("f_eip", 32'(eip), 32'd1);
    @(negedge clk);
    rst = 1'b1;
    irq = '0;
    @(posedge clk);
    #1;
    chk("f_eip_rst", 32'(eip), 32'd0);
    rst = 1'b0;
    rd_chk("f_pend0", 12'h080, 32'd0);
    rd_chk("f_prio3", 12'h00C, 32'd0);
    rd_chk("f_en0", 12'h100, 32'd0);
    rd_chk("f_thr0", 12'h200, 32'd0);
    rd_chk("f_clm0", 12'h204, 32'd0);

    // random traffic against the reference model
    do_reset();
    for (int i = 0; i < 32; i++) m_prio[i] = 0;
    for (int k = 0; k < 2; k++) begin
      m_en[k] = '0;
      m_thr[k] = 0;
      last[k] = 0;
    end
    m_ip = '0;
    m_mask = '0;
    for (int it = 0; it < 150; it++) begin
      op = int'($urandom_range(0, 6));
      c  = int'($urandom_range(0, 1));
      case (op)
        0: begin
          id = int'($urandom_range(0, 31));
          d = $urandom;
          wr(12'(4 * id), d);
          if (id != 0) m_prio[id] = int'(d & 32'h7);
          rd_chk("r_prio", 12'(4 * id), 32'(m_prio[id]));
        end
        1: begin
          d = $urandom;
          wr(12'(32'h100 + 4 * c), d);
          m_en[c] = d & 32'hFFFF_FFFE;
          rd_chk("r_en", 12'(32'h100 + 4 * c), m_en[c]);
        end
        2: begin
          d = $urandom & 32'hFFFF_FFFB;
          wr(12'(32'h200 + 8 * c), d);
          m_thr[c] = int'(d & 32'h7);
          rd_chk("r_thr", 12'(32'h200 + 8 * c), 32'(m_thr[c]));
        end
        3: begin
          @(negedge clk);
          irq = irq ^ ($urandom & $urandom & $urandom);
        end
        4: begin
          id = m_maxid(c);
          rd_chk("r_claim", 12'(32'h204 + 8 * c), 32'(id));
          if (id != 0) m_ip[id] = 1'b0;
          last[c] = id;
        end
        5: begin
          id = ($urandom_range(0, 1) == 1) ? last[c]
                                            : int'($urandom_range(0, 35));
          wr(12'(32'h204 + 8 * c), 32'(id));
          if (id >= 1 && id < 32 && m_en[c][id]) m_mask[id] = 1'b0;
        end
        default: rd_chk("r_pend", 12'h080, m_ip);
      endcase
      idle(3);
      m_settle();
      chk("r_eip", 32'(eip),
          {30'd0, m_maxid(1) != 0, m_maxid(0) != 0});
    end
    rd_chk("r_pend_end", 12'h080, m_ip);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/apb4_plic_ctx.md
APB4_PLIC_CTX -- requirements
Module: apb4_plic_ctx

Interface
REQ-001 SHALL have parameter IRQ_NUM, default 32, meaning source count including reserved ID 0 (legal 2..32).
REQ-002 SHALL have parameter CTX_NUM, default 2, meaning target contexts (legal 1..4).
REQ-003 SHALL have parameter PRIO_WIDTH, default 3, meaning priority bits per source (legal 1..7).
REQ-004 SHALL have port clk_i, input, 1, meaning sole clock; all logic on rising edge.
REQ-005 SHALL have port rst_i, input, 1, meaning synchronous active-high reset.
REQ-006 SHALL have APB4 slave ports paddr_i[11:0], psel_i, penable_i, pwrite_i, pwdata_i[31:0] (inputs), prdata_o[31:0], pready_o, pslverr_o (outputs).
REQ-007 SHALL have port irq_i, input, IRQ_NUM, meaning device sources; bit 0 ignored.
REQ-008 SHALL have port eip_o, output, CTX_NUM, meaning registered external-interrupt request per context.

Function
REQ-009 SHALL tie pready_o to 1; access completes when psel_i&penable_i.
REQ-010 SHALL map priority[i] at 0x000+4*i (i=1..IRQ_NUM-1, RW, low PRIO_WIDTH bits); offset 0x000 reads 0, writes ignored.
REQ-011 SHALL map pending at 0x080 (RO, bit i = IP[i], bit 0 always 0).
REQ-012 SHALL map enable[c] at 0x100+4*c (RW, bit 0 forced 0), threshold[c] at 0x200+8*c (RW), claim/complete[c] at 0x204+8*c.
REQ-013 SHALL assert pslverr_o for unmapped offsets and writes to pending; such accesses have no side effect; prdata_o is 0 outside read access.
REQ-014 SHALL, per source, pass through plic_gateway: IP[i] set in cycle after gateway valid; gateway then masks source until completed.
REQ-015 SHALL compute per context max ID: highest priority among IP&enable[c] with priority > threshold[c]; tie -> lowest ID; none -> 0.
REQ-016 SHALL drive eip_o[c] = (max ID[c] != 0) registered, one cycle latency.
REQ-017 SHALL on claim read of context c return max ID[c] in same access and clear IP of that ID next cycle; ID 0 -> no side effect.
REQ-018 SHALL on complete write of ID to context c clear gateway mask of that ID only if 1<=ID<IRQ_NUM and enable[c][ID]=1; otherwise silently ignore.
REQ-019 SHALL give claim priority over new-valid set of same ID in same cycle (IP cleared).
REQ-020 SHALL treat priority 0 as never-interrupting; a source pending with priority 0 stays pending.
REQ-021 SHALL treat in-service source's level changes as invisible until complete; complete with irq_i still high re-pends next cycle.

Reset
REQ-022 SHALL on rst_i clear priority, pending, enable, threshold, gateway masks, edge state and eip_o to 0.
REQ-023 SHALL, if rst_i asserted during an APB access, discard that access's side effects.

Configuration
REQ-024 SHALL, with PLIC_EDGE_TRIG_EN defined, add trigger-type register at 0x084 (RW, bit i=1 -> rising-edge source, bit 0 forced 0).
REQ-025 SHALL in edge mode register irq_i and generate one-cycle valid on 0->1; edges while masked are dropped.
REQ-026 SHALL without PLIC_EDGE_TRIG_EN treat all sources as level; 0x084 unmapped (pslverr_o=1).

Structure
REQ-027 SHALL place address offsets (0x000,0x080,0x084,0x100,0x200,0x204), max parameter limits and PRIO_WIDTH-independent constants in package plic_pkg.
REQ-028 SHALL implement per-source gating in sub-module plic_gateway (inputs clk_i, rst_i, irq, edge_sel, claim, comp; output valid).
REQ-029 SHALL implement max-ID search as a combinational loop per context, no extra pipeline stage.

Verification
REQ-030 SHALL check: prio[3]=2, prio[5]=2, enable[0]=0x28, threshold[0]=1, irq_i[3] and [5] high -> eip_o[0]=1, claim[0] reads 3, then 5 after complete 3 dropped irq[3].
REQ-031 SHALL check: threshold[1]=2, prio[7]=2, enable[1]=0x80, irq_i[7]=1 -> eip_o[1] stays 0; threshold[1]=1 -> eip_o[1]=1 next cycle.
REQ-032 SHALL check: claim with no eligible source reads 0, pending unchanged; complete ID 9 on context whose enable[9]=0 leaves source 9 masked.
REQ-033 SHALL check: write 0x080 -> pslverr_o=1, pending unchanged; read 0x300 -> pslverr_o=1, prdata_o=0.
REQ-034 SHALL check (PLIC_EDGE_TRIG_EN): trigger bit 4=1, single pulse irq_i[4] -> pending bit 4 set once; second pulse before complete ignored; pulse after complete re-pends.
REQ-035 SHALL check: rst_i asserted with pending 0x0000_0028 and eip_o=2'b01 -> all registers read 0 and eip_o=0 cycle after.
